// File: rtl/alu_issue_ctrl_if.sv
// Bundle between the ALU issue controller and its environment: instruction
// handshake, the ALU operand/result bus, writeback status and debug RF port.
interface alu_issue_ctrl_if #(
  parameter int n = 32
);
  logic          instr_valid;
  logic          instr_ready;
  logic [11:0]   instr;
  logic [2:0]    alu_op;
  logic [n-1:0]  alu_r2;
  logic [n-1:0]  alu_r3;
  logic [n-1:0]  alu_r1;
  logic          alu_cout;
  logic          alu_cout2;
  logic          done;
  logic [n-1:0]  result;
  logic          carry;
  logic [2:0]    dbg_addr;
  logic [n-1:0]  dbg_data;

  // Environment side: instruction source, external ALU and debug reader.
  modport master (
    output instr_valid, instr, alu_r1, alu_cout, alu_cout2, dbg_addr,
    input  instr_ready, alu_op, alu_r2, alu_r3, done, result, carry, dbg_data
  );

  // Controller side.
  modport slave (
    input  instr_valid, instr, alu_r1, alu_cout, alu_cout2, dbg_addr,
    output instr_ready, alu_op, alu_r2, alu_r3, done, result, carry, dbg_data
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Four-state issue controller: accepts a register-format instruction, reads
// two operands from an 8-entry RF, drives the external ALU and writes back.
module alu_issue_ctrl #(
  parameter int n = 32
) (
  input  logic           clk,
  input  logic           rst,
  alu_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_LDI = 3'b111;

  state_t        state;
  state_t        state_next;
  logic [11:0]   instr_q;
  logic [n-1:0]  rf [8];
  logic [2:0]    op_q;
  logic [n-1:0]  r2_q;
  logic [n-1:0]  r3_q;
  logic [n-1:0]  result_q;
  logic          carry_q;

  logic [2:0]    op;
  logic [2:0]    rd;
  logic [2:0]    rs;
  logic [2:0]    rt;
  logic [n-1:0]  exec_result;
  logic          exec_carry;

  assign op = instr_q[11:9];
  assign rd = instr_q[8:6];
  assign rs = instr_q[5:3];
  assign rt = instr_q[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.instr_valid) state_next = READ;
      READ: state_next = EXEC;
      EXEC: state_next = WB;
      WB:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // LDI bypasses the ALU with the zero-extended {rs,rt} immediate.
  always_comb begin
    exec_result = bus.alu_r1;
    exec_carry  = 1'b0;
    if (op == OP_LDI) begin
      exec_result      = '0;
      exec_result[5:0] = instr_q[5:0];
    end
    if (op == OP_ADD) exec_carry = bus.alu_cout;
    if (op == OP_SUB) exec_carry = bus.alu_cout2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q  <= '0;
      op_q     <= '0;
      r2_q     <= '0;
      r3_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.instr_valid) instr_q <= bus.instr;
        READ: begin
          op_q <= op;
          r2_q <= rf[rs];
          r3_q <= rf[rt];
        end
        EXEC: begin
          result_q <= exec_result;
          carry_q  <= exec_carry;
        end
        WB:   rf[rd] <= result_q;
        default: ;
      endcase
    end
  end

  assign bus.instr_ready = (state == IDLE);
  assign bus.done        = (state == WB);
  assign bus.alu_op      = op_q;
  assign bus.alu_r2      = r2_q;
  assign bus.alu_r3      = r3_q;
  assign bus.result      = result_q;
  assign bus.carry       = carry_q;
  assign bus.dbg_data    = rf[bus.dbg_addr];

endmodule
